// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU in the EX stage: one quotient bit per cycle,
// stalls IF..EX while busy and returns {remainder, quotient} with a one-cycle ready pulse.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   divisor_q;
  logic               quo_neg_q;
  logic               rem_neg_q;
  logic [2*WIDTH-1:0] result_q;

  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fixed;
  logic               accept;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    op1_neg = signed_div & opdata1[WIDTH-1];
    op2_neg = signed_div & opdata2[WIDTH-1];
    op1_abs = op1_neg ? -opdata1 : opdata1;
    op2_abs = op2_neg ? -opdata2 : opdata2;

    // rem < divisor always holds, so the trial difference fits in WIDTH+1 bits
    // and its top bit is a reliable borrow.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};

    quo_fix = quo_neg_q ? -quo_q : quo_q;
    rem_fix = rem_neg_q ? -rem_q : rem_q;
    fixed   = {rem_fix, quo_fix};

    accept  = (state == S_IDLE) & start & ~annul;
    stall   = accept | (((state == S_DIVZERO) | (state == S_ON)) & ~annul);
    ready   = (state == S_END) & ~annul;
    // The fixed-up value is visible during END itself; the hold register keeps it afterwards.
    result  = ready ? fixed : result_q;
  end

  // NOTE: asynchronous reset clears every register, including the datapath,
  // and all sequential updates use non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (opdata2 == '0) begin
              state     <= S_DIVZERO;
              rem_q     <= opdata1;
              quo_q     <= '1;
              divisor_q <= '0;
              quo_neg_q <= 1'b0;
              rem_neg_q <= 1'b0;
            end else begin
              state     <= S_ON;
              rem_q     <= '0;
              quo_q     <= op1_abs;
              divisor_q <= op2_abs;
              quo_neg_q <= op1_neg ^ op2_neg;
              rem_neg_q <= op1_neg;
            end
          end
        end

        S_DIVZERO: begin
          state <= annul ? S_IDLE : S_END;
        end

        S_ON: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            if (!trial[WIDTH]) begin
              rem_q <= trial[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= shifted[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) state <= S_END;
          end
        end

        S_END: begin
          if (!annul) result_q <= fixed;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
